// File: rtl/board_io_ctrl.sv
// ---------------------------------------------------------------------------
// board_io_ctrl
//
// Board-level I/O front end sitting between the FPGA pins and the SoC GPIO
// port. Three independent sub-blocks run in parallel on io_mainClk:
//   - clock divider : io_clkDiv toggle output plus io_clkTick rise strobe
//   - switch path   : 2-flop sync + per-bit debounce into io_gpio_read,
//                     with one-cycle io_swChange pulses
//   - LED path      : io_gpio_write gated by a global PWM dimmer
//
// Ports
//   io_mainClk        in   1         board clock, rising edge
//   io_asyncReset_n   in   1         asynchronous active-low reset
//   io_sw             in   NUM_SW    raw asynchronous switch pins
//   io_gpio_read      out  NUM_SW    debounced switch levels
//   io_swChange       out  NUM_SW    one-cycle pulse per changed read bit
//   io_gpio_write     in   NUM_LED   SoC GPIO write bits
//   io_ledBrightness  in   PWM_BITS  global duty (0 off, all-ones always on)
//   io_led            out  NUM_LED   LED pins
//   io_clkDiv         out  1         divided clock (route via global buffer)
//   io_clkTick        out  1         strobe for the cycle io_clkDiv rises
// ---------------------------------------------------------------------------
module board_io_ctrl #(
    parameter int NUM_SW          = 16,
    parameter int NUM_LED         = 16,
    parameter int CLK_DIV         = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PWM_BITS        = 4
) (
    input  logic                io_mainClk,
    input  logic                io_asyncReset_n,
    input  logic [NUM_SW-1:0]   io_sw,
    output logic [NUM_SW-1:0]   io_gpio_read,
    output logic [NUM_SW-1:0]   io_swChange,
    input  logic [NUM_LED-1:0]  io_gpio_write,
    input  logic [PWM_BITS-1:0] io_ledBrightness,
    output logic [NUM_LED-1:0]  io_led,
    output logic                io_clkDiv,
    output logic                io_clkTick
);

    // -----------------------------------------------------------------------
    // Parameter legality
    // -----------------------------------------------------------------------
    if ((CLK_DIV % 2) != 0 || CLK_DIV < 2) begin : g_bad_clk_div
        $error("board_io_ctrl: CLK_DIV must be even and >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("board_io_ctrl: DEBOUNCE_CYCLES must be >= 1");
    end
    if (NUM_SW < 1 || NUM_SW > 32) begin : g_bad_num_sw
        $error("board_io_ctrl: NUM_SW must be in 1..32");
    end
    if (NUM_LED < 1 || NUM_LED > 32) begin : g_bad_num_led
        $error("board_io_ctrl: NUM_LED must be in 1..32");
    end
    if (PWM_BITS < 1 || PWM_BITS > 8) begin : g_bad_pwm_bits
        $error("board_io_ctrl: PWM_BITS must be in 1..8");
    end

    // -----------------------------------------------------------------------
    // Local constants
    // -----------------------------------------------------------------------
    localparam int DIV_HALF = CLK_DIV / 2;
    localparam int DIV_W    = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV_HALF - 1);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

    // -----------------------------------------------------------------------
    // Clock divider
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;

    // io_clkTick is loaded with the value io_clkDiv is about to take, so it
    // is high exactly while io_clkDiv sits in its first high cycle.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            div_cnt    <= '0;
            io_clkDiv  <= 1'b0;
            io_clkTick <= 1'b0;
        end else if (div_cnt == DIV_TC) begin
            div_cnt    <= '0;
            io_clkDiv  <= ~io_clkDiv;
            io_clkTick <= ~io_clkDiv;
        end else begin
            div_cnt    <= div_cnt + DIV_W'(1);
            io_clkTick <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Switch synchroniser and debounce
    // -----------------------------------------------------------------------
    logic [NUM_SW-1:0] sw_sync1;
    logic [NUM_SW-1:0] sw_sync2;
    logic [DB_W-1:0]   db_cnt [NUM_SW];

    // The counter tracks how long sync2 has disagreed with the accepted
    // level; any agreement (including a bounce back) clears it.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            sw_sync1     <= '0;
            sw_sync2     <= '0;
            io_gpio_read <= '0;
            io_swChange  <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sw_sync1 <= io_sw;
            sw_sync2 <= sw_sync1;
            for (int i = 0; i < NUM_SW; i++) begin
                io_swChange[i] <= 1'b0;
                if (sw_sync2[i] == io_gpio_read[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TC) begin
                    io_gpio_read[i] <= sw_sync2[i];
                    io_swChange[i]  <= 1'b1;
                    db_cnt[i]       <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // LED PWM dimmer
    // -----------------------------------------------------------------------
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] bright_shadow;
    logic                pwm_on;

    // All-ones is forced fully on; otherwise the compare would give
    // (2^N-1)/2^N duty.
    assign pwm_on = (pwm_cnt < bright_shadow) || (bright_shadow == PWM_MAX);

    // Shadow only reloads at the period boundary so a mid-period brightness
    // write never produces a runt or stretched pulse.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            pwm_cnt       <= '0;
            bright_shadow <= '0;
            io_led        <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == '0) begin
                bright_shadow <= io_ledBrightness;
            end
            io_led <= io_gpio_write & {NUM_LED{pwm_on}};
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_board_io_ctrl
//
// Two instances share stimulus: u_dut (CLK_DIV=2) and u_dut6 (CLK_DIV=6).
// A reference model derives expectations from edge counts and switch
// sample history; directed steps follow, then a randomized run.
// ---------------------------------------------------------------------------
module tb_board_io_ctrl;

    localparam int NSW    = 16;
    localparam int NLED   = 16;
    localparam int DB     = 4;
    localparam int PB     = 4;
    localparam int PER    = 16;
    localparam int DIV_A  = 2;
    localparam int HALF_A = 1;
    localparam int DIV_B  = 6;
    localparam int HALF_B = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NSW-1:0]  sw;
    logic [NLED-1:0] gw;
    logic [PB-1:0]   bright;

    logic [NSW-1:0]  a_read, a_chg, b_read, b_chg;
    logic [NLED-1:0] a_led, b_led;
    logic            a_div, a_tick, b_div, b_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_io_ctrl #(
        .NUM_SW(NSW), .NUM_LED(NLED), .CLK_DIV(DIV_A),
        .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB)
    ) u_dut (
        .io_mainClk(clk), .io_asyncReset_n(rst_n), .io_sw(sw),
        .io_gpio_read(a_read), .io_swChange(a_chg), .io_gpio_write(gw),
        .io_ledBrightness(bright), .io_led(a_led),
        .io_clkDiv(a_div), .io_clkTick(a_tick)
    );

    board_io_ctrl #(
        .NUM_SW(NSW), .NUM_LED(NLED), .CLK_DIV(DIV_B),
        .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB)
    ) u_dut6 (
        .io_mainClk(clk), .io_asyncReset_n(rst_n), .io_sw(sw),
        .io_gpio_read(b_read), .io_swChange(b_chg), .io_gpio_write(gw),
        .io_ledBrightness(bright), .io_led(b_led),
        .io_clkDiv(b_div), .io_clkTick(b_tick)
    );

    // ---------------- reference model ----------------
    logic [NSW-1:0]  m_read, m_chg;
    logic [NLED-1:0] m_led;
    logic            m_div_a, m_tick_a, m_div_b, m_tick_b;
    int              m_n;
    int              m_shadow;
    logic [NSW-1:0]  hist [$];

    // A switch bit flips once the last DB synchronised samples (the raw
    // samples taken 2..DB+1 edges ago) all disagree with the accepted level.
    always @(posedge clk or negedge rst_n) begin : model
        logic [NSW-1:0] flip;
        logic           all_diff;
        int             cur;
        int             k;
        if (!rst_n) begin
            m_read   <= '0;
            m_chg    <= '0;
            m_led    <= '0;
            m_div_a  <= 1'b0;
            m_tick_a <= 1'b0;
            m_div_b  <= 1'b0;
            m_tick_b <= 1'b0;
            m_n      <= 0;
            m_shadow <= 0;
            hist.delete();
            for (int j = 0; j < DB + 2; j++) hist.push_back('0);
        end else begin
            flip = '0;
            for (int i = 0; i < NSW; i++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= DB; j++) begin
                    if (hist[hist.size() - 1 - j][i] == m_read[i]) all_diff = 1'b0;
                end
                flip[i] = all_diff;
            end
            m_read <= m_read ^ flip;
            m_chg  <= flip;
            hist.push_back(sw);
            if (hist.size() > DB + 2) void'(hist.pop_front());

            cur = m_n % PER;
            m_led <= ((cur < m_shadow) || (m_shadow == PER - 1)) ? gw : '0;
            if (cur == 0) m_shadow <= int'(bright);

            k = m_n + 1;
            m_n      <= k;
            m_div_a  <= ((k / HALF_A) % 2) == 1;
            m_tick_a <= (k % DIV_A) == HALF_A;
            m_div_b  <= ((k / HALF_B) % 2) == 1;
            m_tick_b <= (k % DIV_B) == HALF_B;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_read",  32'(a_read),  32'(m_read));
        check("a_chg",   32'(a_chg),   32'(m_chg));
        check("a_led",   32'(a_led),   32'(m_led));
        check("a_div",   32'(a_div),   32'(m_div_a));
        check("a_tick",  32'(a_tick),  32'(m_tick_a));
        check("b_read",  32'(b_read),  32'(m_read));
        check("b_led",   32'(b_led),   32'(m_led));
        check("b_div",   32'(b_div),   32'(m_div_b));
        check("b_tick",  32'(b_tick),  32'(m_tick_b));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic count_on(input int n, output int on);
        on = 0;
        repeat (n) begin
            @(negedge clk);
            check_all();
            if (a_led == 16'hA5A5) on++;
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int on;
        int need;
        rst_n  = 1'b0;
        sw     = '0;
        gw     = '0;
        bright = '0;

        repeat (3) @(negedge clk);
        check("rst_read", 32'(a_read), 32'd0);
        check("rst_led",  32'(a_led),  32'd0);
        check("rst_div",  32'(a_div),  32'd0);
        check("rst_tick", 32'(a_tick), 32'd0);
        rst_n = 1'b1;

        // divider patterns for both ratios
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check_all();
            if (k <= 8) begin
                check("div2_clk",  32'(a_div),  32'(k % 2));
                check("div2_tick", 32'(a_tick), 32'(k % 2));
                check("div2_read", 32'(a_read), 32'd0);
                check("div2_led",  32'(a_led),  32'd0);
            end
            check("div6_clk",  32'(b_div),  32'((k % 6) >= 3));
            check("div6_tick", 32'(b_tick), 32'((k % 6) == 3));
        end

        // switch 3 rises and holds: accepted after the 6th edge
        sw[3] = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            check_all();
            check("db_read3", 32'(a_read[3]), 32'(e >= 5));
            check("db_chg3",  32'(a_chg[3]),  32'(e == 5));
        end
        // 3-cycle glitch low is rejected
        sw[3] = 1'b0;
        step(3);
        sw[3] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            check_all();
            check("glitch_read3", 32'(a_read[3]), 32'd1);
            check("glitch_chg3",  32'(a_chg[3]),  32'd0);
        end

        // brightness sweep
        gw = 16'hA5A5;
        bright = 4'd4;
        step(32);
        count_on(16, on);
        check("duty4", 32'(on), 32'd4);
        bright = 4'd0;
        step(32);
        count_on(16, on);
        check("duty0", 32'(on), 32'd0);
        bright = 4'd15;
        step(32);
        count_on(16, on);
        check("duty15", 32'(on), 32'd16);

        // brightness 2 -> 12 written while pwm_cnt is 5
        bright = 4'd2;
        step(32);
        need = (5 - (m_n % PER) + PER) % PER;
        step(need);
        bright = 4'd12;
        count_on(11, on);
        check("midper_old", 32'(on), 32'd0);
        count_on(16, on);
        check("midper_new", 32'(on), 32'd12);

        // reset while switch 5 is two counts into its debounce
        sw[5] = 1'b1;
        step(4);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_read", 32'(a_read), 32'd0);
        check("mrst_chg",  32'(a_chg),  32'd0);
        check("mrst_led",  32'(a_led),  32'd0);
        check("mrst_div",  32'(a_div),  32'd0);
        check("mrst_tick", 32'(a_tick), 32'd0);
        check("mrst_bdiv", 32'(b_div),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            check_all();
            check("mrst_read5", 32'(a_read[5]), 32'(e >= 5));
            check("mrst_chg5",  32'(a_chg[5]),  32'(e == 5));
            if (e == 0) check("mrst_led_dark", 32'(a_led), 32'd0);
        end

        // randomized run with one mid-run reset
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3, 0) == 0) sw = sw ^ 16'(32'd1 << $urandom_range(15, 0));
            if ((c % 4) == 0) gw = 16'($urandom);
            if ((c % 40) == 0) bright = 4'($urandom);
            if (c == 700) rst_n = 1'b0;
            if (c == 703) rst_n = 1'b1;
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
